// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-register load/flush enables, valid tracking,
// multi-cycle unit stalls, branch redirects, halt and interrupt drain/trap entry.
module pipeline_ctrl #(
    parameter int STAGES    = 5,
    parameter int EXEC_IDX  = 1,
    parameter int IRQ_LINES = 2,
    parameter int CNT_W     = 16,
    localparam int CAUSE_W  = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic                 unit_start,
    input  logic                 unit_busy,
    input  logic                 unit_done,
    input  logic                 redirect,
    input  logic                 halt_req,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic                 irq_enable,
    output logic [STAGES-1:0]    stage_en,
    output logic [STAGES-1:0]    stage_flush,
    output logic [STAGES-1:0]    valid,
    output logic                 irq_take,
    output logic [CAUSE_W-1:0]   irq_cause,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cycles
);

    typedef enum logic [1:0] {RUN, WAIT_UNIT, HALT, IRQ_DRAIN} state_t;

    // FRONT covers registers 0..EXEC_IDX; BUBBLE is the register just behind execute
    localparam logic [STAGES-1:0] FRONT  = STAGES'((1 << (EXEC_IDX + 1)) - 1);
    localparam logic [STAGES-1:0] BUBBLE = STAGES'(1 << (EXEC_IDX + 1));

    state_t              state, state_next;
    logic [STAGES-1:0]   shifted, valid_next;
    logic [CAUSE_W-1:0]  lowest, cause_next;
    logic                stall, pending, take_next;

    always_comb begin
        stage_en    = '0;
        stage_flush = '0;
        state_next  = state;
        cause_next  = irq_cause;
        take_next   = 1'b0;
        stall       = (unit_start | unit_busy) & ~unit_done;
        pending     = (|irq) & irq_enable;
        shifted     = {valid[STAGES-2:0], fetch_valid};
        lowest      = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (irq[i]) lowest = CAUSE_W'(i);
        end

        if (reset) begin
            stage_flush = '1;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        state_next = WAIT_UNIT;
                    end else begin
                        stage_en = '1;
                        if (redirect) begin
                            stage_flush = FRONT;
                        end else if (halt_req) begin
                            state_next = HALT;
                        end else if (pending) begin
                            state_next = IRQ_DRAIN;
                            cause_next = lowest;
                        end
                    end
                end
                WAIT_UNIT: begin
                    if (unit_done) begin
                        stage_en   = '1;
                        state_next = RUN;
                    end
                end
                HALT: begin
                    stage_en    = ~FRONT;
                    stage_flush = BUBBLE;
                    if (!halt_req) state_next = RUN;
                end
                IRQ_DRAIN: begin
                    stage_en    = ~FRONT;
                    stage_flush = FRONT | BUBBLE;
                end
                default: state_next = RUN;
            endcase
        end

        // Flush wins over load, so a flushed register always ends up invalid
        valid_next = ((shifted & stage_en) | (valid & ~stage_en)) & ~stage_flush;

        // Trap is taken on the edge where the back-end becomes empty
        if (!reset && state == IRQ_DRAIN && (valid_next & ~FRONT) == '0) begin
            take_next  = 1'b1;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            valid        <= '0;
            irq_take     <= 1'b0;
            irq_cause    <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_next;
            valid     <= valid_next;
            irq_take  <= take_next;
            irq_cause <= cause_next;
            halted    <= (state_next == HALT);
            if (!stage_en[0] && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a pipeline-occupancy model.
module tb_pipeline_ctrl;

    localparam int STAGES    = 5;
    localparam int EXEC_IDX  = 1;
    localparam int IRQ_LINES = 2;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = 63;

    localparam logic [STAGES-1:0] FRONT = 5'b00011;
    localparam logic [STAGES-1:0] BUB   = 5'b00100;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_HALT  = 2;
    localparam int M_DRAIN = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fetch_valid, unit_start, unit_busy, unit_done;
    logic                 redirect, halt_req, irq_enable;
    logic [IRQ_LINES-1:0] irq;
    logic [STAGES-1:0]    stage_en, stage_flush, valid;
    logic                 irq_take, halted;
    logic                 irq_cause;
    logic [CNT_W-1:0]     stall_cycles;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int                m_mode;
    logic [STAGES-1:0] m_valid;
    logic              m_take, m_cause;
    int                m_stall;

    pipeline_ctrl #(
        .STAGES(STAGES), .EXEC_IDX(EXEC_IDX), .IRQ_LINES(IRQ_LINES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
        .unit_start(unit_start), .unit_busy(unit_busy), .unit_done(unit_done),
        .redirect(redirect), .halt_req(halt_req), .irq(irq), .irq_enable(irq_enable),
        .stage_en(stage_en), .stage_flush(stage_flush), .valid(valid),
        .irq_take(irq_take), .irq_cause(irq_cause), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check mid-cycle outputs against the model, then advance the model
    task automatic applyStimulus();
        logic [STAGES-1:0] exp_en, exp_fl, shifted, nv;
        int   nmode;
        logic ntake, ncause;
        bit   stall, pend;
        @(negedge clk);
        stall   = (unit_start || unit_busy) && !unit_done;
        pend    = (|irq) && irq_enable;
        shifted = {m_valid[STAGES-2:0], fetch_valid};
        nv      = m_valid;
        nmode   = m_mode;
        ntake   = 1'b0;
        ncause  = m_cause;
        exp_en  = '0;
        exp_fl  = '0;
        if (reset) begin
            exp_fl = '1;
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (stall) begin
                        nmode = M_WAIT;
                    end else begin
                        exp_en = '1;
                        nv     = shifted;
                        if (redirect) begin
                            exp_fl = FRONT;
                            nv     = shifted & ~FRONT;
                        end else if (halt_req) begin
                            nmode = M_HALT;
                        end else if (pend) begin
                            nmode  = M_DRAIN;
                            ncause = irq[0] ? 1'b0 : 1'b1;
                        end
                    end
                end
                M_WAIT: begin
                    if (unit_done) begin
                        exp_en = '1;
                        nv     = shifted;
                        nmode  = M_RUN;
                    end
                end
                M_HALT: begin
                    exp_en = ~FRONT;
                    exp_fl = BUB;
                    nv     = (m_valid & FRONT) | (shifted & ~FRONT & ~BUB);
                    if (!halt_req) nmode = M_RUN;
                end
                default: begin
                    exp_en = ~FRONT;
                    exp_fl = FRONT | BUB;
                    nv     = shifted & ~FRONT & ~BUB;
                    if (nv == '0) begin
                        ntake = 1'b1;
                        nmode = M_RUN;
                    end
                end
            endcase
        end

        checkOutput("stage_en", 32'(stage_en), 32'(exp_en));
        checkOutput("stage_flush", 32'(stage_flush), 32'(exp_fl));
        checkOutput("valid", 32'(valid), 32'(m_valid));
        checkOutput("irq_take", 32'(irq_take), 32'(m_take));
        checkOutput("irq_cause", 32'(irq_cause), 32'(m_cause));
        checkOutput("halted", 32'(halted), 32'(m_mode == M_HALT));
        checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));

        if (reset) begin
            m_mode = M_RUN; m_valid = '0; m_take = 1'b0; m_cause = 1'b0; m_stall = 0;
        end else begin
            if (!exp_en[0] && m_stall < CNT_MAX) m_stall++;
            m_mode = nmode; m_valid = nv; m_take = ntake; m_cause = ncause;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; unit_start = 1'b0; unit_busy = 1'b0;
        unit_done = 1'b0; redirect = 1'b0; halt_req = 1'b0; irq = '0; irq_enable = 1'b0;
        @(posedge clk);
        #1;
        m_mode = M_RUN; m_valid = '0; m_take = 1'b0; m_cause = 1'b0; m_stall = 0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        // Fill the pipe one register per cycle
        fetch_valid = 1'b1;
        applyStimulus();
        checkOutput("fill_1", 32'(valid), 32'(5'b00001));
        repeat (4) applyStimulus();
        checkOutput("fill_5", 32'(valid), 32'(5'b11111));
        checkOutput("fill_stall", 32'(stall_cycles), 32'd0);

        // Multi-cycle unit: 1 start + 32 busy cycles frozen, advance on done
        unit_start = 1'b1;
        applyStimulus();
        unit_start = 1'b0; unit_busy = 1'b1;
        repeat (32) applyStimulus();
        unit_busy = 1'b0; unit_done = 1'b1;
        applyStimulus();
        unit_done = 1'b0;
        checkOutput("unit_stall_count", 32'(stall_cycles), 32'd33);

        // Redirect on a full pipe
        redirect = 1'b1;
        applyStimulus();
        redirect = 1'b0;
        checkOutput("redirect_valid", 32'(valid), 32'(5'b11100));
        repeat (3) applyStimulus();

        // Interrupt while full; lines change mid-drain without affecting the cause
        irq = 2'b10; irq_enable = 1'b1;
        applyStimulus();
        irq = 2'b01;
        applyStimulus();
        checkOutput("drain_no_take", 32'(irq_take), 32'd0);
        irq = 2'b00;
        repeat (2) applyStimulus();
        checkOutput("irq_take_pulse", 32'(irq_take), 32'd1);
        checkOutput("irq_cause_latched", 32'(irq_cause), 32'd1);
        checkOutput("drain_back_empty", 32'(valid[4:2]), 32'd0);
        applyStimulus();
        checkOutput("irq_take_one_cycle", 32'(irq_take), 32'd0);
        repeat (4) applyStimulus();

        // Halt held ten cycles, then released
        halt_req = 1'b1;
        applyStimulus();
        checkOutput("halted_set", 32'(halted), 32'd1);
        repeat (3) applyStimulus();
        checkOutput("halt_back_empty", 32'(valid[4:2]), 32'd0);
        repeat (6) applyStimulus();
        halt_req = 1'b0;
        applyStimulus();
        checkOutput("halt_released", 32'(halted), 32'd0);

        // Long halt drives the stall counter into saturation
        halt_req = 1'b1;
        repeat (40) applyStimulus();
        checkOutput("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));
        halt_req = 1'b0;
        repeat (5) applyStimulus();

        // Reset during WAIT_UNIT
        unit_start = 1'b1;
        applyStimulus();
        unit_start = 1'b0; unit_busy = 1'b1; reset = 1'b1;
        applyStimulus();
        checkOutput("rst_wait_valid", 32'(valid), 32'd0);
        checkOutput("rst_wait_stall", 32'(stall_cycles), 32'd0);
        checkOutput("rst_wait_en", 32'(stage_en), 32'd0);
        checkOutput("rst_wait_flush", 32'(stage_flush), 32'(5'b11111));
        reset = 1'b0; unit_busy = 1'b0;
        repeat (5) applyStimulus();

        // Reset during IRQ_DRAIN must not produce a trap
        irq = 2'b01;
        applyStimulus();
        irq = 2'b00; reset = 1'b1;
        applyStimulus();
        checkOutput("rst_drain_take", 32'(irq_take), 32'd0);
        checkOutput("rst_drain_cause", 32'(irq_cause), 32'd0);
        reset = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("rst_drain_no_late_take", 32'(irq_take), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            fetch_valid = $urandom_range(0, 3) != 0;
            unit_start  = ($urandom_range(0, 9) == 0);
            unit_busy   = ($urandom_range(0, 7) == 0);
            unit_done   = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            halt_req    = ($urandom_range(0, 9) == 0);
            irq         = IRQ_LINES'($urandom_range(0, 3));
            irq_enable  = ($urandom_range(0, 2) != 0);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5: number of pipeline registers controlled, indexed 0 (IF/ID) to STAGES-1 (last writeback register).
REQ-002 SHALL have parameter EXEC_IDX, default 1: index of the register feeding the execute stage; range 0..STAGES-2.
REQ-003 SHALL have parameter IRQ_LINES, default 2: number of level-sensitive interrupt inputs.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-005 SHALL have the ports below; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_valid  in  1  valid instruction presented to register 0
- unit_start  in  1  register EXEC_IDX holds a multi-cycle op that has not started
- unit_busy  in  1  multi-cycle unit is iterating
- unit_done  in  1  one-cycle pulse: result ready
- redirect  in  1  execute resolved a taken branch or jump
- halt_req  in  1  level: freeze fetch/issue
- irq  in  IRQ_LINES  interrupt lines
- irq_enable  in  1  global interrupt enable
- stage_en  out  STAGES  per-register load enable
- stage_flush  out  STAGES  per-register clear of control bits
- valid  out  STAGES  per-register valid tracking
- irq_take  out  1  one-cycle pulse: trap entry
- irq_cause  out  clog2(IRQ_LINES) or 1  index of the line taken
- halted  out  1  held in HALT
- stall_cycles  out  CNT_W  count of cycles with stage 0 not loaded

Function
REQ-006 SHALL implement states RUN, WAIT_UNIT, HALT, IRQ_DRAIN.
REQ-007 In RUN with no event SHALL drive stage_en all-ones and stage_flush zero; valid[0] loads fetch_valid and valid[i] loads valid[i-1].
REQ-008 SHALL treat unit_start or unit_busy, when unit_done is low, as a stall: all stage_en=0, all valid held, and the state is WAIT_UNIT.
REQ-009 In WAIT_UNIT SHALL hold until the unit_done pulse, then advance every register in that cycle and return to RUN; the freeze latency is zero cycles (combinational from unit_start).
REQ-010 On redirect in RUN, SHALL assert stage_flush[0..EXEC_IDX] and clear valid[0..EXEC_IDX] on the next edge, while registers above EXEC_IDX advance normally.
REQ-011 Redirect SHALL take priority over halt_req and irq in the same cycle; a stall SHALL take priority over redirect.
REQ-012 When halt_req is high in RUN and there is no stall or redirect, SHALL enter HALT.
REQ-013 In HALT, stage_en[0..EXEC_IDX]=0; stage_flush[EXEC_IDX+1] and stage_en[EXEC_IDX+1] are asserted, so a bubble is inserted; higher registers drain.
REQ-014 In HALT, halted=1; when halt_req drops, SHALL return to RUN on the next edge.
REQ-015 Interrupt pending is (|irq) & irq_enable. In RUN with pending set and no stall, redirect or halt_req, SHALL latch irq_cause as the lowest-index active line and enter IRQ_DRAIN.
REQ-016 In IRQ_DRAIN, SHALL flush and hold registers 0..EXEC_IDX with their valid bits cleared, and let higher registers drain with a bubble inserted at EXEC_IDX+1.
REQ-017 When valid[EXEC_IDX+1..STAGES-1] are all zero, SHALL pulse irq_take for exactly one cycle and return to RUN.
REQ-018 A change in irq lines during IRQ_DRAIN SHALL NOT change the latched irq_cause; a deasserted irq SHALL still complete the trap.
REQ-019 stall_cycles SHALL increment on every cycle with stage_en[0]=0 and saturate at all-ones, with no wrap-around.

Reset
REQ-020 On reset, the state SHALL be RUN; valid, stage_en, irq_take, halted, irq_cause and stall_cycles SHALL be zero; stage_flush SHALL be all-ones.
REQ-021 Reset mid-operation in any state SHALL abandon it with no irq_take pulse; the first post-reset cycle SHALL behave as RUN.

Verification
REQ-022 Defaults, fetch_valid=1 for 5 cycles -> valid goes 00001, 00011, ... 11111, one bit per cycle; stall_cycles=0.
REQ-023 unit_start at cycle 3, unit_busy for 32 cycles, then unit_done -> stage_en=0 for 33 cycles, all advance on the done cycle, stall_cycles=33.
REQ-024 valid=11111 with redirect for 1 cycle -> next valid=11100, stage_flush=00011 during that cycle.
REQ-025 irq=2'b10 with irq_enable=1 while the pipe is full -> irq_take one-cycle pulse exactly after valid[4:2] reach 0, i.e. 3 cycles later; irq_cause=1.
REQ-026 halt_req held 10 cycles, then released -> halted=1 from the next cycle, back-end empties in 3 cycles, RUN resumes one cycle after release.
REQ-027 Reset asserted during IRQ_DRAIN and WAIT_UNIT -> every output equals its REQ-020 value on the next edge, and no irq_take pulse occurs.
